// File: rtl/qoi_enc_pkg.sv
// Shared types, opcodes, register offsets and hash for the QOI chunk encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qoi_enc_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } rgba_t;

  localparam logic [7:0] QOI_OP_INDEX = 8'h00;
  localparam logic [7:0] QOI_OP_DIFF  = 8'h40;
  localparam logic [7:0] QOI_OP_LUMA  = 8'h80;
  localparam logic [7:0] QOI_OP_RUN   = 8'hC0;
  localparam logic [7:0] QOI_OP_RGB   = 8'hFE;
  localparam logic [7:0] QOI_OP_RGBA  = 8'hFF;

  localparam logic [2:0] REG_R     = 3'd0;
  localparam logic [2:0] REG_G     = 3'd1;
  localparam logic [2:0] REG_B     = 3'd2;
  localparam logic [2:0] REG_A     = 3'd3;
  localparam logic [2:0] REG_CTRL  = 3'd4;
  localparam logic [2:0] REG_FIFO  = 3'd5;
  localparam logic [2:0] REG_COUNT = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_EMIT = 2'd2
  } enc_state_t;

  // Only the low 6 bits of each channel matter for a result taken mod 64.
  function automatic logic [5:0] qoi_hash(input rgba_t p);
    logic [5:0] h;
    h = p.r[5:0] * 6'd3 + p.g[5:0] * 6'd5 + p.b[5:0] * 6'd7 + p.a[5:0] * 6'd11;
    return h;
  endfunction

endpackage

// File: rtl/qoi_encoder_if.sv
// CPU register window bus for the QOI encoder (select, strobe, offset, data).
// Latency: read data is combinational from the offset.
// Backpressure: none on the bus; the CPU polls status.ready.
interface qoi_encoder_if;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] data_i;
  logic [7:0] data_o;

  modport master (output cs, we, addr, data_i, input data_o);
  modport slave  (input cs, we, addr, data_i, output data_o);
endinterface

// File: rtl/qoi_enc_fifo.sv
// Synchronous byte FIFO with count/full/empty and a synchronous clear.
// Latency: a pushed byte is visible at the head one edge after the push.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keep count.
module qoi_enc_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/qoi_encoder.sv
// Memory-mapped QOI chunk encoder: CPU pushes RGBA pixels, chunk bytes land in an output FIFO.
// Latency: push at edge N -> EVAL in cycle N+1 -> k-byte chunk complete in FIFO at edge N+1+k.
// Backpressure: ready = idle && FIFO free >= 6; push/FLUSH when not ready is dropped, sets sticky overflow.
// Build option QOI_ENC_INDEX_EN adds the 64-entry colour index and INDEX chunks.
module qoi_encoder
  import qoi_enc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input logic          clk,
  input logic          rst,
  qoi_encoder_if.slave bus
);
  localparam int    CW        = $clog2(FIFO_DEPTH) + 1;
  localparam rgba_t PREV_INIT = '{r: 8'd0, g: 8'd0, b: 8'd0, a: 8'd255};

  enc_state_t    state;
  logic [7:0]    r_q, g_q, b_q;
  rgba_t         px_q, prev;
  logic [5:0]    run, run_n;
  logic [47:0]   sr, sr_n;
  logic [2:0]    len, len_n;
  logic          overflow;

  logic          f_push, f_pop, f_full, f_empty;
  logic [7:0]    f_head;
  logic [CW-1:0] f_count;

  logic          wr_en, start_wr, flush_wr, push_wr, ready, busy, is_run;
  logic [7:0]    run_byte;
  logic [7:0]    dr, dg, db, dr2, dg2, db2, dg32, rg8, bg8;
  logic [39:0]   chunk;
  logic [2:0]    clen;
  logic [5:0]    hash;
  logic          idx_hit;

  assign wr_en    = bus.cs && bus.we;
  assign start_wr = wr_en && (bus.addr == REG_CTRL) && bus.data_i[0];
  assign flush_wr = wr_en && (bus.addr == REG_CTRL) && bus.data_i[1] && !bus.data_i[0];
  assign push_wr  = wr_en && (bus.addr == REG_A);
  assign busy     = (state != ST_IDLE);
  assign ready    = !busy && (f_count <= CW'(FIFO_DEPTH - 6));
  assign is_run   = (px_q == prev);
  assign run_byte = QOI_OP_RUN | {2'b00, run - 6'd1};

  // Wrapping channel differences; biasing by the range floor turns signed range tests into unsigned compares.
  assign dr   = px_q.r - prev.r;
  assign dg   = px_q.g - prev.g;
  assign db   = px_q.b - prev.b;
  assign dr2  = dr + 8'd2;
  assign dg2  = dg + 8'd2;
  assign db2  = db + 8'd2;
  assign dg32 = dg + 8'd32;
  assign rg8  = dr - dg + 8'd8;
  assign bg8  = db - dg + 8'd8;

`ifdef QOI_ENC_INDEX_EN
  rgba_t       index_mem [64];
  logic [63:0] index_vld;
  rgba_t       idx_val;

  assign hash    = qoi_hash(px_q);
  assign idx_val = index_vld[hash] ? index_mem[hash] : '0;
  assign idx_hit = (idx_val == px_q);

  // Valid bits stand in for clearing all 64 entries to zero on reset/START.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  index_vld       <= '0;
    else if (start_wr)                         index_vld       <= '0;
    else if (state == ST_EVAL && !is_run)      index_vld[hash] <= 1'b1;
  end

  // Index storage written on every non-run pixel.
  always_ff @(posedge clk) begin
    if (state == ST_EVAL && !is_run) index_mem[hash] <= px_q;
  end
`else
  assign hash    = 6'd0;
  assign idx_hit = 1'b0;
`endif

  // Pick the highest-priority chunk for a non-run pixel, left-aligned in 5 bytes.
  always_comb begin
    chunk = '0;
    clen  = 3'd0;
    if (idx_hit) begin
      chunk = {QOI_OP_INDEX | {2'b00, hash}, 32'h0};
      clen  = 3'd1;
    end else if (px_q.a == prev.a && dr2 < 8'd4 && dg2 < 8'd4 && db2 < 8'd4) begin
      chunk = {QOI_OP_DIFF | {2'b00, dr2[1:0], dg2[1:0], db2[1:0]}, 32'h0};
      clen  = 3'd1;
    end else if (px_q.a == prev.a && dg32 < 8'd64 && rg8 < 8'd16 && bg8 < 8'd16) begin
      chunk = {QOI_OP_LUMA | {2'b00, dg32[5:0]}, rg8[3:0], bg8[3:0], 24'h0};
      clen  = 3'd2;
    end else if (px_q.a == prev.a) begin
      chunk = {QOI_OP_RGB, px_q.r, px_q.g, px_q.b, 8'h00};
      clen  = 3'd4;
    end else begin
      chunk = {QOI_OP_RGBA, px_q.r, px_q.g, px_q.b, px_q.a};
      clen  = 3'd5;
    end
  end

  // Assemble the byte sequence for EVAL: run accounting plus an optional pending-run prefix.
  always_comb begin
    sr_n  = '0;
    len_n = 3'd0;
    run_n = run;
    if (is_run) begin
      if (run == 6'd61) begin
        sr_n  = {QOI_OP_RUN | 8'd61, 40'h0};
        len_n = 3'd1;
        run_n = 6'd0;
      end else begin
        run_n = run + 6'd1;
      end
    end else if (run != 6'd0) begin
      sr_n  = {run_byte, chunk};
      len_n = clen + 3'd1;
      run_n = 6'd0;
    end else begin
      sr_n  = {chunk, 8'h00};
      len_n = clen;
      run_n = 6'd0;
    end
  end

  // Encoder FSM: pixel/control register writes, EVAL load, EMIT byte shifting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      px_q     <= '0;
      prev     <= PREV_INIT;
      run      <= '0;
      sr       <= '0;
      len      <= '0;
      overflow <= 1'b0;
    end else if (start_wr) begin
      state    <= ST_IDLE;
      prev     <= PREV_INIT;
      run      <= '0;
      sr       <= '0;
      len      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && bus.addr == REG_R) r_q <= bus.data_i;
      if (wr_en && bus.addr == REG_G) g_q <= bus.data_i;
      if (wr_en && bus.addr == REG_B) b_q <= bus.data_i;
      if ((push_wr || flush_wr) && !ready) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (push_wr && ready) begin
            px_q  <= '{r: r_q, g: g_q, b: b_q, a: bus.data_i};
            state <= ST_EVAL;
          end else if (flush_wr && ready && run != 6'd0) begin
            sr    <= {run_byte, 40'h0};
            len   <= 3'd1;
            run   <= '0;
            state <= ST_EMIT;
          end
        end
        ST_EVAL: begin
          run <= run_n;
          sr  <= sr_n;
          len <= len_n;
          if (!is_run) prev <= px_q;
          state <= (len_n == 3'd0) ? ST_IDLE : ST_EMIT;
        end
        ST_EMIT: begin
          sr  <= {sr[39:0], 8'h00};
          len <= len - 3'd1;
          if (len == 3'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign f_push = (state == ST_EMIT);
  assign f_pop  = bus.cs && !bus.we && (bus.addr == REG_FIFO);

  qoi_enc_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_wr),
    .push     (f_push),
    .push_dat (sr[47:40]),
    .pop      (f_pop),
    .head     (f_head),
    .count    (f_count),
    .full     (f_full),
    .empty    (f_empty)
  );

  // Register read mux; FIFO data reads as zero when empty.
  always_comb begin
    bus.data_o = 8'h00;
    case (bus.addr)
      REG_CTRL:  bus.data_o = {ready, busy, f_empty, f_full, overflow, 3'b000};
      REG_FIFO:  bus.data_o = f_empty ? 8'h00 : f_head;
      REG_COUNT: bus.data_o = 8'(f_count);
      default:   ;
    endcase
  end
endmodule
